// File: rtl/syn_gpu_pkg.sv
// rtl/syn_gpu_pkg.sv - shared GPU types and constants
package syn_gpu_pkg;

  localparam int P_X_W      = 10;
  localparam int P_Y_W      = 10;
  localparam int P_FF_DEPTH = 256;

  typedef struct packed {
    logic [P_X_W-1:0] x;
    logic [P_Y_W-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } ff_arb_state_t;

endpackage

// File: rtl/syn_rr_arb.sv
// rtl/syn_rr_arb.sv - combinational N-way round-robin priority picker
module syn_rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] cand;
  logic          found;

  // Scan starting one past the last winner so the previous winner has lowest priority.
  always_comb begin
    gnt     = '0;
    gnt_idx = last;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/syn_gpu_ff_arb.sv
// rtl/syn_gpu_ff_arb.sv - round-robin write arbiter, read gate and flush sequencer for the point FIFO
module syn_gpu_ff_arb
  import syn_gpu_pkg::*;
#(
  parameter int NUM_AGENTS = 4,
  parameter int DEPTH      = P_FF_DEPTH,
  parameter int WIDTHX     = P_X_W,
  parameter int WIDTHY     = P_Y_W,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                                 clk_ir,
  input  logic                                 rst_il,
  input  logic [NUM_AGENTS-1:0]                agent_req_i,
  input  logic [NUM_AGENTS*(WIDTHX+WIDTHY)-1:0] agent_pt_i,
  output logic [NUM_AGENTS-1:0]                agent_gnt_o,
  input  logic                                 cons_rd_req_i,
  output logic                                 cons_rd_ack_o,
  input  logic                                 flush_i,
  output logic                                 flush_done_o,
  output logic                                 ff_wr_en_o,
  output logic [WIDTHX+WIDTHY-1:0]             ff_wr_pt_o,
  output logic                                 ff_rd_en_o,
  input  logic                                 ff_empty_i,
  input  logic                                 ff_full_i,
  input  logic [WIDTHX+WIDTHY-1:0]             ff_waddr_i,
  input  logic [WIDTHX+WIDTHY-1:0]             ff_raddr_i,
  output logic [CNT_W-1:0]                     occ_o
);

  localparam int PT_W = WIDTHX + WIDTHY;
  localparam int IW   = $clog2(NUM_AGENTS);

  ff_arb_state_t state_q, state_d;

  logic [NUM_AGENTS-1:0] gnt_q;
  logic [NUM_AGENTS-1:0] pick;
  logic [IW-1:0]         pick_idx;
  logic [IW-1:0]         last_q;
  logic                  wr_en_q;
  logic [PT_W-1:0]       pt_q;
  logic [CNT_W-1:0]      occ_q;
  logic [PT_W-1:0]       agent_pt [NUM_AGENTS];

  logic room;
  logic grant_ok;
  logic rd_en;
  logic ack;
  logic done;

  for (genvar a = 0; a < NUM_AGENTS; a++) begin : g_unpack
    assign agent_pt[a] = agent_pt_i[a*PT_W +: PT_W];
  end

  syn_rr_arb #(
    .N  (NUM_AGENTS),
    .IW (IW)
  ) u_rr_arb (
    .req     (agent_req_i),
    .last    (last_q),
    .gnt     (pick),
    .gnt_idx (pick_idx)
  );

  // The grant already registered is counted as occupied so back-to-back grants never overfill.
  assign room = ({1'b0, occ_q} + (CNT_W+1)'(wr_en_q)) < (CNT_W+1)'(DEPTH);

  always_comb begin
    state_d  = state_q;
    grant_ok = 1'b0;
    rd_en    = 1'b0;
    ack      = 1'b0;
    done     = 1'b0;
    case (state_q)
      ARB: begin
        grant_ok = !flush_i && room && !ff_full_i;
        rd_en    = !flush_i && cons_rd_req_i && (occ_q != '0) && !ff_empty_i;
        ack      = rd_en;
        if (flush_i) state_d = FLUSH;
      end
      FLUSH: begin
        rd_en = (occ_q != '0);
        if ((occ_q == '0) && !wr_en_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_ir or posedge rst_il) begin
    if (rst_il) begin
      state_q <= ARB;
      gnt_q   <= '0;
      wr_en_q <= 1'b0;
      pt_q    <= '0;
      last_q  <= IW'(NUM_AGENTS - 1);
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_q + CNT_W'(wr_en_q) - CNT_W'(rd_en);
      if (grant_ok && (|agent_req_i)) begin
        gnt_q   <= pick;
        wr_en_q <= 1'b1;
        pt_q    <= agent_pt[pick_idx];
        last_q  <= pick_idx;
      end else begin
        gnt_q   <= '0;
        wr_en_q <= 1'b0;
      end
    end
  end

  assign agent_gnt_o   = gnt_q;
  assign ff_wr_en_o    = wr_en_q;
  assign ff_wr_pt_o    = pt_q;
  assign ff_rd_en_o    = rd_en;
  assign cons_rd_ack_o = ack;
  assign flush_done_o  = done;
  assign occ_o         = occ_q;

  a_no_wr_when_full: assert property (@(posedge clk_ir) disable iff (rst_il)
    !(ff_wr_en_o && ff_full_i));

  a_occ_in_range: assert property (@(posedge clk_ir) disable iff (rst_il)
    ({1'b0, occ_q} <= (CNT_W+1)'(DEPTH)));

  a_no_overflow: assert property (@(posedge clk_ir) disable iff (rst_il)
    !(wr_en_q && !rd_en && ({1'b0, occ_q} == (CNT_W+1)'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk_ir) disable iff (rst_il)
    !(rd_en && !wr_en_q && (occ_q == '0)));

  a_ptrs_known: assert property (@(posedge clk_ir) disable iff (rst_il)
    !$isunknown({ff_waddr_i, ff_raddr_i}));

endmodule

// File: tb/tb_syn_gpu_ff_arb.sv
// tb/tb_syn_gpu_ff_arb.sv - self-checking bench for syn_gpu_ff_arb
module tb_syn_gpu_ff_arb;
  import syn_gpu_pkg::*;

  localparam int NA    = 4;
  localparam int DEPTH = 256;
  localparam int PT_W  = P_X_W + P_Y_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [NA-1:0]     req;
  logic [NA*PT_W-1:0] pts;
  logic [NA-1:0]     gnt;
  logic              cons, ack, flush, done;
  logic              wr_en, rd_en, empty, full, fne;
  logic [PT_W-1:0]   wr_pt, waddr, raddr;
  logic [CNT_W-1:0]  occ;
  int                ctl_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  syn_gpu_ff_arb #(.NUM_AGENTS(NA), .DEPTH(DEPTH)) dut (
    .clk_ir        (clk),
    .rst_il        (rst),
    .agent_req_i   (req),
    .agent_pt_i    (pts),
    .agent_gnt_o   (gnt),
    .cons_rd_req_i (cons),
    .cons_rd_ack_o (ack),
    .flush_i       (flush),
    .flush_done_o  (done),
    .ff_wr_en_o    (wr_en),
    .ff_wr_pt_o    (wr_pt),
    .ff_rd_en_o    (rd_en),
    .ff_empty_i    (empty),
    .ff_full_i     (full),
    .ff_waddr_i    (waddr),
    .ff_raddr_i    (raddr),
    .occ_o         (occ)
  );

  // Stand-in for the FF controller's own occupancy; fne lets empty lag behind.
  always @(posedge clk or posedge rst)
    if (rst) ctl_cnt <= 0;
    else     ctl_cnt <= ctl_cnt + (wr_en ? 1 : 0) - (rd_en ? 1 : 0);
  assign empty = (ctl_cnt == 0) && !fne;
  assign full  = (ctl_cnt == DEPTH);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Behavioural model: occupancy count, pending grant (-1 none), last winner, mode 0/1/2.
  int m_occ, m_pend, m_last, m_mode, m_pick, m_rd, m_a;
  logic [PT_W-1:0] m_pt;

  function automatic int model_rd();
    if (m_mode == 0) return (cons && !flush && m_occ != 0 && !empty) ? 1 : 0;
    if (m_mode == 1) return (m_occ != 0) ? 1 : 0;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_occ = 0; m_pend = -1; m_last = NA - 1; m_mode = 0; m_pt = '0;
    end else begin
      m_rd   = model_rd();
      m_pick = -1;
      if (m_mode == 0 && !flush && (m_occ + (m_pend >= 0 ? 1 : 0)) < DEPTH && !full)
        for (int k = 1; k <= NA; k++) begin
          m_a = (m_last + k) % NA;
          if (m_pick < 0 && req[m_a]) m_pick = m_a;
        end
      case (m_mode)
        0: if (flush) m_mode = 1;
        1: if (m_occ == 0 && m_pend < 0) m_mode = 2;
        default: m_mode = 0;
      endcase
      m_occ  = m_occ + (m_pend >= 0 ? 1 : 0) - m_rd;
      m_pend = m_pick;
      if (m_pick >= 0) begin
        m_last = m_pick;
        m_pt   = pts[m_pick*PT_W +: PT_W];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt",   gnt,   (m_pend >= 0) ? (1 << m_pend) : 0);
      chk("wr_en", wr_en, (m_pend >= 0) ? 1 : 0);
      if (m_pend >= 0) chk("wr_pt", wr_pt, m_pt);
      chk("rd_en", rd_en, model_rd());
      chk("ack",   ack,   (m_mode == 0) ? model_rd() : 0);
      chk("done",  done,  (m_mode == 2) ? 1 : 0);
      chk("occ",   occ,   m_occ);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pt(input int a, input int x, input int y);
    pts[a*PT_W +: PT_W] = {P_X_W'(x), P_Y_W'(y)};
  endtask

  task automatic do_reset();
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
  endtask

  int cnt[NA];
  int gcnt, rdc, donec, done_i, fg_i;
  logic [NA-1:0] fg;

  initial begin
    rst = 1'b1; req = '0; cons = 1'b0; flush = 1'b0; fne = 1'b0;
    waddr = '0; raddr = '0;
    for (int a = 0; a < NA; a++) set_pt(a, a + 1, 100 + a);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_occ", occ, 0);
    chk("rst_done", done, 0);

    // Empty at occ=0 even if the controller's empty flag lags
    cyc(); rst = 1'b0; cons = 1'b1; fne = 1'b1;
    @(negedge clk);
    chk("ack_at_occ0", ack, 0);

    // Single agent
    cyc(); cons = 1'b0; fne = 1'b0; req = 4'b0100; set_pt(2, 5, 7);
    cyc(); req = '0;
    @(negedge clk);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_wr_en", wr_en, 1);
    chk("single_pt", wr_pt, {P_X_W'(5), P_Y_W'(7)});
    cyc();
    @(negedge clk);
    chk("single_occ", occ, 1);

    // Fairness from reset
    do_reset();
    cyc(); req = 4'hF;
    for (int a = 0; a < NA; a++) cnt[a] = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      @(negedge clk);
      chk("fair_order", gnt, 1 << (i % NA));
      if (gnt != 0) cnt[i % NA]++;
    end
    cyc(); req = '0;
    for (int a = 0; a < NA; a++) chk("fair_share", cnt[a], 4);

    // Fill to capacity
    do_reset();
    cyc(); req = 4'hF;
    gcnt = 0;
    for (int i = 0; i < 270; i++) begin
      cyc();
      @(negedge clk);
      if (gnt != 0) gcnt++;
    end
    chk("fill_grants", gcnt, DEPTH);
    chk("fill_occ", occ, DEPTH);
    cyc(); cons = 1'b1;
    @(negedge clk);
    chk("fill_pop_ack", ack, 1);
    cyc(); cons = 1'b0;
    gcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      if (gnt != 0) gcnt++;
    end
    chk("fill_one_more", gcnt, 1);
    cyc(); req = '0; cons = 1'b1;
    repeat (245) cyc();
    cyc(); cons = 1'b0;
    @(negedge clk);
    chk("drain_occ", occ, 10);

    // Simultaneous write and pop
    cyc(); req = 4'b0010;
    cyc(); req = '0; cons = 1'b1;
    @(negedge clk);
    chk("simul_gnt", gnt, 4'b0010);
    chk("simul_ack", ack, 1);
    cyc(); cons = 1'b0;
    @(negedge clk);
    chk("simul_occ", occ, 10);

    // Flush
    cyc(); cons = 1'b1;
    repeat (4) cyc();
    cyc(); cons = 1'b0; req = 4'hF; flush = 1'b1;
    @(negedge clk);
    chk("flush_occ", occ, 5);
    rdc = 0; donec = 0; done_i = -1; fg_i = -1; fg = '0;
    for (int i = 1; i <= 14; i++) begin
      cyc(); flush = 1'b0;
      @(negedge clk);
      if (rd_en) rdc++;
      if (done) begin donec++; done_i = i; end
      if (gnt != 0 && fg_i < 0) begin fg = gnt; fg_i = i; end
    end
    chk("flush_rd_cycles", rdc, 5);
    chk("flush_done_cnt", donec, 1);
    chk("flush_done_at", done_i, 7);
    chk("flush_resume_at", fg_i, 9);
    chk("flush_resume_gnt", fg, 4'b0100);

    // Reset mid-operation
    cyc(); req = 4'b1000;
    cyc(); rst = 1'b1; req = 4'b1001;
    @(negedge clk);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_occ", occ, 0);
    chk("midrst_rd_en", rd_en, 0);
    cyc(); rst = 1'b0;
    cyc();
    @(negedge clk);
    chk("midrst_first", gnt, 4'b0001);
    cyc(); req = '0;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/syn_gpu_ff_arb.md
# syn_gpu_ff_arb

Round-robin arbiter and sequencer for the GPU point FIFO (FF) controller. It shares the controller's single write port between up to NUM_AGENTS drawing engines that push `point_t` coordinates. It gates the consumer's read requests and tracks occupancy locally, so the FIFO is never over-written or over-read. On request it flushes the FIFO. It sits between the rasteriser engines and the FF controller, and drives the controller's master-side signals (`wr_en`, `rd_en`, `empty`, `full`, `waddr`, `raddr`).

## Interface
- NUM_AGENTS, 4: number of write requesters (2..8).
- DEPTH, 256: FIFO capacity in points; must equal the FF controller depth.
- WIDTHX, syn_gpu_pkg::P_X_W: x-coordinate width.
- WIDTHY, syn_gpu_pkg::P_Y_W: y-coordinate width.
- CNT_W, $clog2(DEPTH+1): occupancy counter width (derived).

Ports:
- clk_ir  in  1  system clock; all logic on rising edge.
- rst_il  in  1  reset, asynchronous, active-high.
- agent_req_i  in  NUM_AGENTS  per-agent write request; level, held until granted.
- agent_pt_i  in  NUM_AGENTS x point_t  per-agent point; stable while req is high.
- agent_gnt_o  out  NUM_AGENTS  one-hot, one-cycle grant pulse.
- cons_rd_req_i  in  1  consumer pop request.
- cons_rd_ack_o  out  1  pop accepted this cycle.
- flush_i  in  1  single-cycle flush command.
- flush_done_o  out  1  one-cycle pulse when the flush completes.
- ff_wr_en_o  out  1  to FF controller `wr_en`.
- ff_wr_pt_o  out  point_t  write data to FIFO RAM, aligned with ff_wr_en_o.
- ff_rd_en_o  out  1  to FF controller `rd_en`.
- ff_empty_i, ff_full_i  in  1 each  controller status.
- ff_waddr_i, ff_raddr_i  in  point_t each  controller pointers; used for assertions only.
- occ_o  out  CNT_W  current occupancy.

## Operation
- **FSM states.** ARB, FLUSH, DONE. Reset state is ARB.
- **ARB: write side.**
  - Grants one write per cycle when all of the following hold: a requester exists, `occ + wr_pending < DEPTH`, and ff_full_i=0.
  - Selection is round-robin starting from the agent after the last granted agent. After reset, the "last granted" pointer is NUM_AGENTS-1, so agent 0 has first priority.
- **ARB: read side.**
  - cons_rd_ack_o = ff_rd_en_o = cons_rd_req_i & (occ≠0) & ~ff_empty_i. This path is combinational.
- **ARB → FLUSH.** On flush_i. New grants stop immediately; a grant already registered completes. Consumer acks are forced to 0.
- **FLUSH.** ff_rd_en_o=1 every cycle while occ≠0. When occ==0 and no write is pending, go to DONE.
- **DONE.** flush_done_o=1 for one cycle, then return to ARB.
- **flush_i outside ARB.** Ignored.
- **occ update.** occ = occ + wr − rd each cycle. Simultaneous write and read leave occ unchanged. occ saturates at neither end; an attempt to go out of range is an assertion failure.

## Timing
- **Reset values.** All outputs 0; occ=0; FSM=ARB; round-robin pointer=NUM_AGENTS-1.
- **Write latency.** Request sampled in cycle N. agent_gnt_o, ff_wr_en_o and ff_wr_pt_o are all registered and assert together in cycle N+1. occ increments at the end of N+1.
- **wr_pending.** Equals the registered grant (0 or 1) and counts against capacity. This allows back-to-back grants while keeping occ ≤ DEPTH.
- **Agent handshake.** An agent may drop req or change its point in the cycle after gnt. Otherwise req and point are held.
- **Read.** Zero-latency ack. RAM read data comes from the FF controller and is outside this block.
- **Full/empty boundary.**
  - At occ=DEPTH-1 with a grant in flight, no further grant is issued.
  - At occ=0, a consumer request is not acked even if ff_empty_i lags.
- **Reset mid-operation.** An in-flight grant is dropped; the FF controller is reset in the same domain.

## Structure
- Add to syn_gpu_pkg:
  - `point_t` (already present).
  - `ff_arb_state_t` enum (ARB, FLUSH, DONE).
  - Constant `P_FF_DEPTH`, used as the default for DEPTH.
- One sub-module, `syn_rr_arb`: parameterised N-way round-robin priority picker. It takes a request vector and the last grant, and returns a one-hot grant vector, combinationally.
- The top level holds the FSM, the occupancy counter, and the output registers.
- Assertions:
  - `ff_wr_en_o` is never asserted while ff_full_i=1.
  - occ ≤ DEPTH at all times.

## Test plan
- **Single agent.** Agent 2 requests with point (5,7) -> gnt[2] and ff_wr_en_o in the next cycle with ff_wr_pt_o=(5,7); occ=1.
- **Fairness.** All 4 agents request continuously -> grant order 0,1,2,3,0,…; one grant per cycle; each agent gets 25%.
- **Fill to capacity.** Fill to DEPTH=256 with continuous requests -> exactly 256 grants, then no gnt; a consumer pop frees exactly one further grant.
- **Simultaneous write and pop.** occ=10, grant and consumer pop in the same cycle -> occ stays 10; ack=1.
- **Flush.** occ=5 with agents requesting, flush_i pulse -> no new grants; ff_rd_en_o high 5 cycles; flush_done_o pulses; ARB resumes with grant to the next round-robin agent.
- **Reset mid-operation.** Assert rst_il with a grant in flight -> all outputs 0 immediately, occ=0; after release, agent 0 has first priority.
